mf8_flow_ctl: RTL
=================

Name: mf8_flow_ctl

Overview:
- Program-flow controller for the mf8 core.
- Sits between the instruction decoder and the 12-bit PC sequencer (NPC = PC + offset; the offset is +1 or 0 when RJmp=0, and Offs when RJmp=1).
- Turns decoded flow requests (relative jump, relative call, return, skip, memory stall) into the sequencer's Pause/RJmp/Offs controls.
- Owns a small hardware return-address stack and the pipeline flush/skip sequencing.

Parameters:
- STACK_DEPTH, 4, number of 12-bit return-address entries (2..16).
- SP_W, 3, stack-level counter width; must hold 0..STACK_DEPTH.

Ports:
- Clk  input  1  clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- PC_In  input  12  current PC from the sequencer.
- Instr_Valid  input  1  decoded instruction in execute is valid.
- Req_RJmp  input  1  relative jump request.
- Req_RCall  input  1  relative call request.
- Req_Ret  input  1  return request.
- Req_Skip  input  1  skip-next-instruction request (condition already true).
- Offs_Req  input  12  two's-complement offset for RJmp/RCall; target = PC_In + Offs_Req mod 4096.
- Mem_Busy  input  1  data-memory stall.
- Clr_Err  input  1  clears sticky error flags.
- Pause  output  1  to sequencer; hold PC.
- RJmp  output  1  to sequencer; select Offs.
- Offs_Out  output  12  to sequencer offset.
- Flush  output  1  invalidate the fetched instruction this cycle.
- Stk_Level  output  SP_W  number of valid stack entries.
- Stk_Ovf  output  1  sticky; push attempted while full.
- Stk_Unf  output  1  sticky; pop attempted while empty.

Behaviour:
- Reset (async): state=RUN, Stk_Level=0, Stk_Ovf=Stk_Unf=0. Stack RAM contents are don't-care.
- During reset: Pause=0, RJmp=0, Offs_Out=0, Flush=0.
- State register: RUN, FLUSH, SKIP. Flush = (state != RUN), derived from the registered state.
- Pause, RJmp, and Offs_Out are combinational from state and inputs. The sequencer registers them, so every jump takes effect on the next edge.
- Default in all states: Pause=0, RJmp=0, Offs_Out=0 (PC increments).
- Stall has highest priority. Mem_Busy=1 in any state gives Pause=1 and RJmp=0. While stalled:
  - state holds,
  - no stack change,
  - requests are ignored (the decoder re-presents them).
- In FLUSH or SKIP without a stall:
  - Instr_Valid and all Req_* are ignored,
  - PC advances,
  - next state is RUN.
- In RUN with Instr_Valid=1 and Mem_Busy=0, only the highest-priority request acts. Priority: Ret > RCall > RJmp > Skip.
- Ret:
  - RJmp=1.
  - Offs_Out = top - PC_In (mod 4096), so the next PC equals top.
  - Stk_Level decrements. Next state is FLUSH.
  - If the stack is empty: Offs_Out = 0 - PC_In (next PC = 0x000), Stk_Unf is set, level stays 0, next state is FLUSH.
- RCall:
  - Push (PC_In + 1) mod 4096 and increment the level.
  - RJmp=1, Offs_Out=Offs_Req, next state FLUSH.
  - If the stack is full: the push is dropped, Stk_Ovf is set, and the jump is still taken.
- RJmp: RJmp=1, Offs_Out=Offs_Req, next state FLUSH.
- Skip: normal increment, next state SKIP. The following fetched instruction is discarded via Flush.
- No request, or Instr_Valid=0: normal increment, state stays RUN.
- Stack is LIFO; top = entry[Stk_Level-1]. Push and pop occur only on the one arbitrated cycle.
- Sticky flags clear on Clr_Err=1 at the clock edge. If set and clear coincide, set wins.
- Reset asserted mid-flush or mid-stall returns to RUN with an empty stack on the next evaluation; no pending request is retained.

Test Plan:
- Reset, then Instr_Valid=1 with no requests for 3 cycles from PC_In=0x000 → Pause=0, RJmp=0, Flush=0, Stk_Level=0, Stk_Ovf=Stk_Unf=0. PC advances 0x000 → 0x003.
- RJmp at PC_In=0xFFE with Offs_Req=0x005:
  - that cycle: RJmp=1, Offs_Out=0x005;
  - next PC is 0x003 (wrap);
  - next cycle: Flush=1;
  - following cycle: RUN, Flush=0.
- RCall at PC_In=0xFFF with Offs_Req=0x010:
  - push 0x000, Stk_Level=1, Flush next cycle;
  - later Ret at PC_In=0x00F gives Offs_Out=0xFF1, next PC 0x000, Stk_Level=0.
- Mem_Busy=1 coincident with Req_RJmp:
  - Pause=1, RJmp=0, no state change;
  - next cycle Mem_Busy=0 with the request re-presented: RJmp=1.
- Req_Skip plus Req_RJmp in the same cycle → jump wins (RJmp=1, FLUSH). Req_Skip alone gives Flush=1 for exactly one cycle while the PC increments.
- STACK_DEPTH=4:
  - five RCalls: the fifth sets Stk_Ovf and keeps Stk_Level=4;
  - five Rets: the fifth sets Stk_Unf, Offs_Out = -PC_In, next PC 0x000;
  - Clr_Err clears both flags.

Source files
------------

// File: rtl/mf8_flow_ctl_if.sv
// Flow-control bundle between the mf8 decoder/PC sequencer (master) and the
// flow controller (slave).
interface mf8_flow_ctl_if #(
  parameter int SP_W = 3
);
  logic [11:0]     PC_In;
  logic            Instr_Valid;
  logic            Req_RJmp;
  logic            Req_RCall;
  logic            Req_Ret;
  logic            Req_Skip;
  logic [11:0]     Offs_Req;
  logic            Mem_Busy;
  logic            Clr_Err;
  logic            Pause;
  logic            RJmp;
  logic [11:0]     Offs_Out;
  logic            Flush;
  logic [SP_W-1:0] Stk_Level;
  logic            Stk_Ovf;
  logic            Stk_Unf;

  modport master (
    output PC_In, Instr_Valid, Req_RJmp, Req_RCall, Req_Ret, Req_Skip,
           Offs_Req, Mem_Busy, Clr_Err,
    input  Pause, RJmp, Offs_Out, Flush, Stk_Level, Stk_Ovf, Stk_Unf
  );

  modport slave (
    input  PC_In, Instr_Valid, Req_RJmp, Req_RCall, Req_Ret, Req_Skip,
           Offs_Req, Mem_Busy, Clr_Err,
    output Pause, RJmp, Offs_Out, Flush, Stk_Level, Stk_Ovf, Stk_Unf
  );
endinterface

// File: rtl/mf8_flow_ctl.sv
// mf8 program-flow controller: arbitrates jump/call/return/skip requests into
// sequencer Pause/RJmp/Offs controls and owns the hardware return stack.
module mf8_flow_ctl #(
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = 3
) (
  input  logic           Clk,
  input  logic           Reset_n,
  mf8_flow_ctl_if.slave  bus
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] LVL_ONE = SP_W'(1);
  localparam logic [SP_W-1:0] LVL_MAX = SP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_SKIP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [11:0]      r_stk [STACK_DEPTH];
  logic [SP_W-1:0]  r_lvl;
  logic             r_ovf;
  logic             r_unf;

  logic             w_arb;
  logic             w_ret;
  logic             w_call;
  logic             w_jmp;
  logic             w_skip;
  logic             w_empty;
  logic             w_full;
  logic [IDX_W-1:0] w_top_idx;
  logic [IDX_W-1:0] w_push_idx;
  logic [11:0]      w_top;

  // Only one arbitrated request per cycle, and only from RUN without a stall.
  assign w_arb  = (r_state == S_RUN) && bus.Instr_Valid && !bus.Mem_Busy;
  assign w_ret  = w_arb && bus.Req_Ret;
  assign w_call = w_arb && !bus.Req_Ret && bus.Req_RCall;
  assign w_jmp  = w_arb && !bus.Req_Ret && !bus.Req_RCall && bus.Req_RJmp;
  assign w_skip = w_arb && !bus.Req_Ret && !bus.Req_RCall && !bus.Req_RJmp
                  && bus.Req_Skip;

  assign w_empty    = (r_lvl == '0);
  assign w_full     = (r_lvl == LVL_MAX);
  assign w_top_idx  = IDX_W'(r_lvl - LVL_ONE);
  assign w_push_idx = IDX_W'(r_lvl);
  assign w_top      = r_stk[w_top_idx];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_RUN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.Mem_Busy) begin
      if (r_state != S_RUN)              w_state_nxt = S_RUN;
      else if (w_ret || w_call || w_jmp) w_state_nxt = S_FLUSH;
      else if (w_skip)                   w_state_nxt = S_SKIP;
    end
  end

  // Offsets are relative to PC_In, so a return encodes (target - PC) mod 4096.
  always_comb begin
    bus.Pause    = 1'b0;
    bus.RJmp     = 1'b0;
    bus.Offs_Out = 12'd0;
    if (Reset_n) begin
      if (bus.Mem_Busy) begin
        bus.Pause = 1'b1;
      end else if (w_ret) begin
        bus.RJmp     = 1'b1;
        bus.Offs_Out = w_empty ? (12'd0 - bus.PC_In) : (w_top - bus.PC_In);
      end else if (w_call || w_jmp) begin
        bus.RJmp     = 1'b1;
        bus.Offs_Out = bus.Offs_Req;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_lvl <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ret && !w_empty)      r_lvl <= r_lvl - LVL_ONE;
      else if (w_call && !w_full) r_lvl <= r_lvl + LVL_ONE;
      r_ovf <= (w_call && w_full)  || (r_ovf && !bus.Clr_Err);
      r_unf <= (w_ret  && w_empty) || (r_unf && !bus.Clr_Err);
    end
  end

  // Return-address storage carries no reset; validity is tracked by r_lvl.
  always_ff @(posedge Clk) begin
    if (w_call && !w_full) r_stk[w_push_idx] <= bus.PC_In + 12'd1;
  end

  assign bus.Flush     = (r_state != S_RUN);
  assign bus.Stk_Level = r_lvl;
  assign bus.Stk_Ovf   = r_ovf;
  assign bus.Stk_Unf   = r_unf;

endmodule
